vga_stream_out: RTL

Parametrised VGA timing generator and pixel output stage. It owns the H/V counters and issues pixel-fetch requests (x, y) to the frame-memory read path. It re-aligns the returned pixel with delayed sync and data-enable signals, then drives registered RGB and sync outputs to the DAC pins. It can replace the incoming pixel stream with an internal colour-bar test pattern.

---
 rtl/vga_stream_out.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : vga_stream_out
// Description : VGA timing generator with pixel-fetch requests, latency
//               re-alignment of sync/DE, registered RGB/sync outputs and an
//               internal 8-bar colour test pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_stream_out #(
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int CW        = 4,
  parameter int FETCH_LAT = 2
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [3*CW-1:0] iPixel,
  input  logic            iMode,
  output logic            oReq,
  output logic [15:0]     oX,
  output logic [15:0]     oY,
  output logic            oFrameStart,
  output logic [CW-1:0]   oR,
  output logic [CW-1:0]   oG,
  output logic [CW-1:0]   oB,
  output logic            oHsync,
  output logic            oVsync,
  output logic            oDE
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_END = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_BEG  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END  = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_BEG  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END  = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] BAR_LAST   = 16'(H_ACTIVE / 8 - 1);

  // Everything that must travel alongside the memory fetch.
  typedef struct packed {
    logic sel;    // 1 = show colour bars for this pixel
    logic bar_b;
    logic bar_g;
    logic bar_r;
    logic de;
    logic vs;
    logic hs;
  } tap_t;

  logic [15:0] hc;
  logic [15:0] vc;
  logic        h_act;
  logic        v_act;
  logic        mode_q;
  logic [15:0] pix_cnt;
  logic [2:0]  bar_idx;
  tap_t        tap0;
  tap_t        tap_d;

  // Horizontal / vertical position counters; held at the origin during reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? 16'd0 : vc + 16'd1;
    end else begin
      hc <= hc + 16'd1;
    end
  end

  assign h_act = (hc >= H_ACT_BEG) && (hc < H_ACT_END);
  assign v_act = (vc >= V_ACT_BEG) && (vc < V_ACT_END);

  assign oReq        = h_act & v_act;
  assign oX          = oReq ? (hc - H_ACT_BEG) : 16'd0;
  assign oY          = oReq ? (vc - V_ACT_BEG) : 16'd0;
  // Gated by reset so the pulse is seen once, on the first free-running cycle.
  assign oFrameStart = ~iRst & (hc == 16'd0) & (vc == 16'd0);

  // Mode is only picked up at a frame boundary so a frame is never mixed.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      mode_q <= 1'b0;
    end else if (oFrameStart) begin
      mode_q <= iMode;
    end
  end

  // Bar position tracked incrementally; restarts every active line.
  always_ff @(posedge iClk) begin
    if (iRst || !h_act) begin
      pix_cnt <= '0;
      bar_idx <= '0;
    end else if (pix_cnt == BAR_LAST) begin
      pix_cnt <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      pix_cnt <= pix_cnt + 16'd1;
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps
  // each channel onto one inverted bit of the bar index.
  assign tap0.sel   = mode_q;
  assign tap0.bar_r = ~bar_idx[1];
  assign tap0.bar_g = ~bar_idx[2];
  assign tap0.bar_b = ~bar_idx[0];
  assign tap0.de    = oReq;
  assign tap0.vs    = (vc < V_SYNC_END);
  assign tap0.hs    = (hc < H_SYNC_END);

  generate
    if (FETCH_LAT > 0) begin : g_delay
      tap_t line [FETCH_LAT];

      // Delay line matching the memory read latency.
      always_ff @(posedge iClk) begin
        if (iRst) begin
          for (int i = 0; i < FETCH_LAT; i++) line[i] <= '0;
        end else begin
          line[0] <= tap0;
          for (int i = 1; i < FETCH_LAT; i++) line[i] <= line[i-1];
        end
      end

      assign tap_d = line[FETCH_LAT-1];
    end else begin : g_no_delay
      assign tap_d = tap0;
    end
  endgenerate

  // Output register: merge the fetched pixel with the delayed timing.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      oDE    <= 1'b0;
      oHsync <= ~HS_POL;
      oVsync <= ~VS_POL;
    end else begin
      oDE    <= tap_d.de;
      oHsync <= tap_d.hs ? HS_POL : ~HS_POL;
      oVsync <= tap_d.vs ? VS_POL : ~VS_POL;
      if (!tap_d.de) begin
        oR <= '0;
        oG <= '0;
        oB <= '0;
      end else if (tap_d.sel) begin
        oR <= {CW{tap_d.bar_r}};
        oG <= {CW{tap_d.bar_g}};
        oB <= {CW{tap_d.bar_b}};
      end else begin
        oR <= iPixel[CW-1:0];
        oG <= iPixel[2*CW-1:CW];
        oB <= iPixel[3*CW-1:2*CW];
      end
    end
  end

endmodule
`default_nettype wire
